// File: rtl/tv_capture_ctrl.sv
// rtl/tv_capture_ctrl.sv - frame-gated capture controller with decimation, size check and watchdog
module tv_capture_ctrl #(
   parameter int IMAGE_WIDE  = 800,
   parameter int IMAGE_HIGH  = 600,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [3:0]  i_skip,
   input  logic        i_clr_err,
   input  logic [15:0] i_data,
   input  logic        i_hsync,
   input  logic        i_vsync,
   output logic [15:0] o_data,
   output logic        o_de,
   output logic        o_vsync,
   output logic        o_sof,
   output logic        o_eof,
   output logic        o_busy,
   output logic [15:0] o_frame_cnt,
   output logic [11:0] o_line_cnt,
   output logic [11:0] o_pix_cnt,
   output logic        o_err_size,
   output logic        o_err_lost
);

   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {IDLE, SYNC, ARM, CAP, SKIP} state_t;

   state_t            state_q, state_d;
   logic              vs_q, hs_q;
   logic [3:0]        skip_cnt_q, skip_cnt_d;
   logic              stop_pend_q, stop_pend_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [11:0]       pix_q, pix_d, lines_q, lines_d, last_pix_q, last_pix_d;
   logic              width_bad_q, width_bad_d;
   logic [15:0]       data_q, data_d, frame_cnt_q, frame_cnt_d;
   logic              de_q, de_d, vsync_q, vsync_d, sof_q, sof_d, eof_q, eof_d;
   logic [11:0]       line_cnt_q, line_cnt_d, pix_cnt_q, pix_cnt_d;
   logic              err_size_q, err_size_d, err_lost_q, err_lost_d;

   logic vs_rise, vs_fall, vs_edge, line_end, timeout;
   logic cap_start, cap_en, cap_end, stop_now;

   // Edge detection and the capture qualifiers shared by every process below.
   // A stop arriving on the very cycle a capture would begin suppresses it, so no
   // orphan start-of-frame is emitted for a frame that is never delivered.
   always_comb begin
      vs_rise   = i_vsync & ~vs_q;
      vs_fall   = ~i_vsync & vs_q;
      vs_edge   = vs_rise | vs_fall;
      line_end  = hs_q & ~i_hsync;
      timeout   = (state_q != IDLE) && !vs_edge && (wd_q == WD_W'(TIMEOUT_CYC - 1));
      cap_start = (state_q == ARM) && vs_rise && (skip_cnt_q == 4'd0) && !i_stop;
      cap_en    = (cap_start || ((state_q == CAP) && i_vsync)) && !timeout;
      cap_end   = (state_q == CAP) && vs_fall;
      stop_now  = stop_pend_q | i_stop;
   end

   // Next-state logic: capture only between whole frames, decimate via skip_cnt.
   always_comb begin
      state_d     = state_q;
      skip_cnt_d  = skip_cnt_q;
      stop_pend_d = stop_pend_q;
      case (state_q)
         IDLE: begin
            stop_pend_d = 1'b0;
            skip_cnt_d  = 4'd0;
            if (i_start && !i_stop) state_d = SYNC;
         end
         SYNC: begin
            if (i_stop)        state_d = IDLE;
            else if (!i_vsync) state_d = ARM;
         end
         ARM: begin
            if (i_stop) begin
               state_d = IDLE;
            end else if (vs_rise) begin
               if (skip_cnt_q == 4'd0) begin
                  state_d    = CAP;
                  skip_cnt_d = i_skip;
               end else begin
                  state_d    = SKIP;
                  skip_cnt_d = skip_cnt_q - 4'd1;
               end
            end
         end
         CAP, SKIP: begin
            if (i_stop)  stop_pend_d = 1'b1;
            if (vs_fall) state_d = stop_now ? IDLE : ARM;
         end
         default: state_d = IDLE;
      endcase
      if (timeout) state_d = stop_now ? IDLE : SYNC;
   end

   // Watchdog: cycles since the last vsync edge while active.
   always_comb begin
      wd_d = wd_q + WD_W'(1);
      if (state_q == IDLE || vs_edge || timeout) wd_d = '0;
   end

   // Frame-size measurement over captured frames only.
   always_comb begin
      pix_d       = pix_q;
      lines_d     = lines_q;
      last_pix_d  = last_pix_q;
      width_bad_d = width_bad_q;
      if (cap_start) begin
         pix_d       = {11'd0, i_hsync};
         lines_d     = 12'd0;
         width_bad_d = 1'b0;
      end else if (state_q == CAP) begin
         if (line_end) begin
            pix_d      = 12'd0;
            last_pix_d = pix_q;
            if (lines_q != 12'hFFF) lines_d = lines_q + 12'd1;
            if (pix_q != 12'(IMAGE_WIDE)) width_bad_d = 1'b1;
         end else if (i_hsync && i_vsync && pix_q != 12'hFFF) begin
            pix_d = pix_q + 12'd1;
         end
      end
   end

   // Registered stream outputs, frame statistics and sticky error flags.
   // The end-of-frame results use the _d measurement values so a line ending on
   // the same cycle as vsync falls is still counted.
   always_comb begin
      vsync_d     = cap_en;
      de_d        = cap_en & i_hsync;
      data_d      = (cap_en && i_hsync) ? i_data : data_q;
      sof_d       = cap_start;
      eof_d       = cap_end;
      frame_cnt_d = cap_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
      line_cnt_d  = cap_end ? lines_d : line_cnt_q;
      pix_cnt_d   = cap_end ? last_pix_d : pix_cnt_q;
      err_size_d  = err_size_q & ~i_clr_err;
      if (cap_end && (lines_d != 12'(IMAGE_HIGH) || width_bad_d)) err_size_d = 1'b1;
      err_lost_d  = err_lost_q & ~i_clr_err;
      if (timeout) err_lost_d = 1'b1;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         vs_q        <= 1'b0;
         hs_q        <= 1'b0;
         skip_cnt_q  <= 4'd0;
         stop_pend_q <= 1'b0;
         wd_q        <= '0;
         pix_q       <= 12'd0;
         lines_q     <= 12'd0;
         last_pix_q  <= 12'd0;
         width_bad_q <= 1'b0;
         data_q      <= 16'd0;
         de_q        <= 1'b0;
         vsync_q     <= 1'b0;
         sof_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_cnt_q <= 16'd0;
         line_cnt_q  <= 12'd0;
         pix_cnt_q   <= 12'd0;
         err_size_q  <= 1'b0;
         err_lost_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_q        <= i_vsync;
         hs_q        <= i_hsync;
         skip_cnt_q  <= skip_cnt_d;
         stop_pend_q <= stop_pend_d;
         wd_q        <= wd_d;
         pix_q       <= pix_d;
         lines_q     <= lines_d;
         last_pix_q  <= last_pix_d;
         width_bad_q <= width_bad_d;
         data_q      <= data_d;
         de_q        <= de_d;
         vsync_q     <= vsync_d;
         sof_q       <= sof_d;
         eof_q       <= eof_d;
         frame_cnt_q <= frame_cnt_d;
         line_cnt_q  <= line_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         err_size_q  <= err_size_d;
         err_lost_q  <= err_lost_d;
      end
   end

   assign o_data      = data_q;
   assign o_de        = de_q;
   assign o_vsync     = vsync_q;
   assign o_sof       = sof_q;
   assign o_eof       = eof_q;
   assign o_busy      = (state_q != IDLE);
   assign o_frame_cnt = frame_cnt_q;
   assign o_line_cnt  = line_cnt_q;
   assign o_pix_cnt   = pix_cnt_q;
   assign o_err_size  = err_size_q;
   assign o_err_lost  = err_lost_q;

endmodule

// File: tb/tb_tv_capture_ctrl.sv
// tb/tb_tv_capture_ctrl.sv - self-checking bench for tv_capture_ctrl
module tb_tv_capture_ctrl;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int TO = 256;

   logic        clk = 1'b0;
   logic        rst, start, stop, clr, hs, vs;
   logic [3:0]  skip;
   logic [15:0] din;
   logic [15:0] o_data, o_frame_cnt;
   logic [11:0] o_line_cnt, o_pix_cnt;
   logic        o_de, o_vsync, o_sof, o_eof, o_busy, o_err_size, o_err_lost;

   int n_cmp = 0;
   int n_bad = 0;

   // frame-level reference model
   bit running = 0;
   int skip_left = 0;
   int m_frames = 0;
   int m_lines = 0;
   int m_pix = 0;
   bit m_err = 0;
   bit m_lost = 0;
   bit cur_cap = 0;
   bit chk_en = 0;
   int sof_seen = 0, eof_seen = 0, de_seen = 0;
   bit p1_cv = 0, p1_cd = 0, p2_cv = 0;
   logic [15:0] p1_d = '0;
   int base, e0;

   always #5 clk = ~clk;

   tv_capture_ctrl #(.IMAGE_WIDE(W), .IMAGE_HIGH(H), .TIMEOUT_CYC(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_skip(skip),
      .i_clr_err(clr), .i_data(din), .i_hsync(hs), .i_vsync(vs),
      .o_data(o_data), .o_de(o_de), .o_vsync(o_vsync), .o_sof(o_sof), .o_eof(o_eof),
      .o_busy(o_busy), .o_frame_cnt(o_frame_cnt), .o_line_cnt(o_line_cnt),
      .o_pix_cnt(o_pix_cnt), .o_err_size(o_err_size), .o_err_lost(o_err_lost)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // A captured frame appears on the outputs as the input frame delayed by one cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("o_vsync", 32'(o_vsync), 32'(p1_cv));
         chk("o_de", 32'(o_de), 32'(p1_cd));
         chk("o_sof", 32'(o_sof), 32'(p1_cv & ~p2_cv));
         chk("o_eof", 32'(o_eof), 32'(~p1_cv & p2_cv));
         if (p1_cd) chk("o_data", 32'(o_data), 32'(p1_d));
      end
      if (o_sof) sof_seen++;
      if (o_eof) eof_seen++;
      if (o_de)  de_seen++;
      p2_cv = p1_cv;
      p1_cv = cur_cap & vs;
      p1_cd = cur_cap & vs & hs;
      p1_d  = din;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1; cyc(); start = 0;
      if (!running) begin running = 1; skip_left = 0; end
   endtask

   task automatic do_stop();
      stop = 1; cyc(); stop = 0;
      running = 0;
   endtask

   task automatic send_frame(input int nl, input int bad_line, input int bad_w,
                             input int stop_line, input int start_line);
      bit took;
      int w;
      took = 0;
      if (running) begin
         if (skip_left == 0) begin took = 1; skip_left = int'(skip); end
         else skip_left--;
      end
      vs = 0; hs = 0;
      repeat ($urandom_range(3, 6)) cyc();
      cur_cap = took; vs = 1;
      for (int l = 1; l <= nl; l++) begin
         hs = 0;
         repeat ($urandom_range(2, 4)) cyc();
         w = (l == bad_line) ? bad_w : W;
         for (int p = 0; p < w; p++) begin
            hs = 1; din = 16'($urandom);
            start = (p == 0 && l == start_line);
            stop  = (p == 0 && l == stop_line);
            cyc();
            start = 0; stop = 0;
         end
      end
      hs = 0; repeat (2) cyc();
      vs = 0; cur_cap = 0; cyc();
      if (took) begin
         m_frames++;
         m_lines = nl;
         m_pix = (bad_line == nl) ? bad_w : W;
         if (nl != H || (bad_line >= 1 && bad_line <= nl && bad_w != W)) m_err = 1;
      end
      if (stop_line > 0) running = 0;
      if (start_line > 0 && !running) begin running = 1; skip_left = 0; end
   endtask

   task automatic check_frame(input string tag);
      cyc();
      chk({tag, "/frame_cnt"}, 32'(o_frame_cnt), 32'(m_frames[15:0]));
      chk({tag, "/line_cnt"}, 32'(o_line_cnt), 32'(m_lines));
      chk({tag, "/pix_cnt"}, 32'(o_pix_cnt), 32'(m_pix));
      chk({tag, "/err_size"}, 32'(o_err_size), 32'(m_err));
      chk({tag, "/err_lost"}, 32'(o_err_lost), 32'(m_lost));
   endtask

   initial begin
      rst = 1; start = 0; stop = 0; clr = 0; hs = 0; vs = 0; skip = 0; din = 0;
      repeat (3) cyc();
      chk("rst/o_data", 32'(o_data), 0);
      chk("rst/o_de", 32'(o_de), 0);
      chk("rst/o_vsync", 32'(o_vsync), 0);
      chk("rst/o_sof", 32'(o_sof), 0);
      chk("rst/o_eof", 32'(o_eof), 0);
      chk("rst/o_busy", 32'(o_busy), 0);
      chk("rst/frame_cnt", 32'(o_frame_cnt), 0);
      chk("rst/line_cnt", 32'(o_line_cnt), 0);
      chk("rst/pix_cnt", 32'(o_pix_cnt), 0);
      chk("rst/err_size", 32'(o_err_size), 0);
      chk("rst/err_lost", 32'(o_err_lost), 0);
      rst = 0; chk_en = 1; cyc();

      // three well-formed captured frames
      do_start();
      chk("start/busy", 32'(o_busy), 1);
      base = de_seen;
      for (int f = 0; f < 3; f++) begin
         send_frame(H, 0, 0, 0, 0);
         check_frame("basic");
      end
      chk("basic/de_total", 32'(de_seen - base), 32'(3 * W * H));
      chk("basic/sof_total", 32'(sof_seen), 3);
      chk("basic/eof_total", 32'(eof_seen), 3);

      // stop during line 2 lets the frame finish, then the next frame is ignored
      send_frame(H, 0, 0, 2, 0);
      check_frame("stop");
      chk("stop/busy", 32'(o_busy), 0);
      send_frame(H, 0, 0, 0, 0);
      check_frame("after_stop");
      start = 1; stop = 1; cyc(); start = 0; stop = 0;
      chk("start_stop/busy", 32'(o_busy), 0);
      send_frame(H, 0, 0, 0, 0);
      check_frame("start_stop");

      // start mid-frame: that frame is ignored, the following one captured
      send_frame(H, 0, 0, 0, 2);
      check_frame("mid_start");
      send_frame(H, 0, 0, 0, 0);
      check_frame("mid_start_next");

      // decimation: capture one, skip two
      skip = 4'd2;
      base = m_frames;
      for (int f = 0; f < 7; f++) begin
         send_frame(H, 0, 0, 0, 0);
         check_frame("skip");
      end
      chk("skip/captured", 32'(m_frames - base), 3);
      do_stop();
      chk("skip/stop_busy", 32'(o_busy), 0);
      skip = 4'd0;
      do_start();

      // size errors and clearing
      send_frame(H, 3, 7, 0, 0);
      check_frame("err_width");
      clr = 1; cyc(); clr = 0; m_err = 0;
      chk("err_clr", 32'(o_err_size), 0);
      send_frame(5, 0, 0, 0, 0);
      check_frame("err_lines");

      // random frame shapes
      for (int f = 0; f < 4; f++) begin
         int nl, bl;
         nl = $urandom_range(3, 5);
         bl = $urandom_range(0, nl);
         send_frame(nl, bl, $urandom_range(6, 9), 0, 0);
         check_frame("rand");
      end
      clr = 1; cyc(); clr = 0; m_err = 0;

      // vsync stuck high during a capture
      vs = 0; hs = 0; repeat (4) cyc();
      skip_left = 0;
      chk_en = 0; e0 = eof_seen;
      vs = 1; cyc();
      repeat (250) cyc();
      chk("to/lost_early", 32'(o_err_lost), 0);
      chk("to/vsync_early", 32'(o_vsync), 1);
      repeat (50) cyc();
      m_lost = 1;
      chk("to/lost", 32'(o_err_lost), 1);
      chk("to/vsync", 32'(o_vsync), 0);
      chk("to/busy", 32'(o_busy), 1);
      chk("to/no_eof", 32'(eof_seen - e0), 0);
      chk("to/frame_cnt", 32'(o_frame_cnt), 32'(m_frames[15:0]));
      vs = 0; repeat (3) cyc();
      chk_en = 1;
      send_frame(H, 0, 0, 0, 0);
      check_frame("to_next");
      clr = 1; cyc(); clr = 0; m_lost = 0;
      chk("to/clr", 32'(o_err_lost), 0);

      repeat (3) cyc();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tv_capture_ctrl.md
Name: tv_capture_ctrl

Overview:
- Frame-capture controller downstream of the TV-to-YUV422 converter and upstream of the frame-buffer writer.
- Gates the 16-bit YUV422 stream on whole-frame boundaries only, under start/stop commands.
- Supports frame decimation: captures 1 frame, then skips i_skip frames.
- Measures each captured frame's size against IMAGE_WIDE x IMAGE_HIGH, flags mismatch and signal loss, and keeps a captured-frame count.

Parameters:
- IMAGE_WIDE, 800, expected pixels (hsync-high cycles) per line.
- IMAGE_HIGH, 600, expected lines per frame.
- TIMEOUT_CYC, 1048576, cycles with no vsync edge before signal is declared lost.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  pulse: begin capturing.
- i_stop  in  1  pulse: stop after the current frame.
- i_skip  in  4  frames to skip after each captured frame; sampled at each capture start.
- i_clr_err  in  1  pulse: clear sticky error flags.
- i_data  in  16  YUV422 pixel word.
- i_hsync  in  1  line valid, high = pixel valid.
- i_vsync  in  1  frame valid, high during active frame.
- o_data  out  16  gated pixel word.
- o_de  out  1  pixel valid to writer.
- o_vsync  out  1  frame valid to writer; captured frames only.
- o_sof  out  1  one-cycle start-of-frame pulse.
- o_eof  out  1  one-cycle end-of-frame pulse.
- o_busy  out  1  state != IDLE.
- o_frame_cnt  out  16  completed captured frames; wraps.
- o_line_cnt  out  12  line count of last completed captured frame.
- o_pix_cnt  out  12  pixel count of last line of last completed captured frame.
- o_err_size  out  1  sticky: captured frame size mismatch.
- o_err_lost  out  1  sticky: vsync timeout.

Behaviour:
- Reset: all outputs 0; state IDLE; skip_cnt, stop_pending, watchdog and measurement counters 0.
- Edge detect: vs_q/hs_q are 1-cycle registered copies of the inputs. vs_rise = i_vsync & ~vs_q; vs_fall = ~i_vsync & vs_q; line_end = hs_q & ~i_hsync.
- FSM states: IDLE, SYNC, ARM, CAP, SKIP.
  - IDLE: i_start -> SYNC; stop_pending <= 0; skip_cnt <= 0, so the first frame after start is captured.
  - SYNC: wait for i_vsync == 0, then -> ARM. Capture never starts mid-frame.
  - ARM: on vs_rise, if skip_cnt == 0 -> CAP and skip_cnt <= i_skip; else -> SKIP and skip_cnt <= skip_cnt - 1.
  - CAP: on vs_fall -> IDLE if stop_pending, else ARM.
  - SKIP: on vs_fall -> IDLE if stop_pending, else ARM.
- i_start when not IDLE: ignored.
- i_stop:
  - IDLE: ignored.
  - SYNC/ARM: -> IDLE next cycle.
  - CAP/SKIP: sets stop_pending; the frame completes.
  - i_start and i_stop in the same cycle in IDLE: stop wins, stay IDLE.
- cap_en = (ARM & vs_rise & skip_cnt == 0) | (CAP & i_vsync).
- Registered outputs, 1-cycle latency:
  - o_vsync <= cap_en.
  - o_de <= cap_en & i_hsync.
  - o_data <= i_data when cap_en & i_hsync, else hold.
  - o_sof <= ARM & vs_rise & skip_cnt == 0, so it coincides with o_vsync's first high cycle.
  - o_eof <= CAP & vs_fall, so it coincides with o_vsync's first low cycle.
- Measurement, captured frames only:
  - pix counter counts i_hsync & i_vsync cycles, saturates at 4095, clears at line_end.
  - At line_end: line counter +1 (saturating); if pix != IMAGE_WIDE, set width_bad.
  - At o_eof: o_line_cnt <= lines; o_pix_cnt <= pix of last line; frame_cnt +1 (wraps 0xFFFF -> 0).
  - At o_eof: o_err_size <= 1 if lines != IMAGE_HIGH or width_bad.
  - lines and width_bad clear at capture start.
- Watchdog:
  - Counts in SYNC/ARM/CAP/SKIP; clears on any vsync edge and in IDLE.
  - At TIMEOUT_CYC: o_err_lost <= 1; o_vsync/o_de forced 0.
  - No o_eof pulse and no frame_cnt increment for an aborted frame.
  - Next state: IDLE if stop_pending, else SYNC.
- i_clr_err clears both sticky flags; a new error in the same cycle wins (flag stays 1).
- Reset mid-frame: outputs drop to 0 next cycle; no o_eof.

Test Plan:
- IMAGE_WIDE=8, IMAGE_HIGH=4. i_start, then 3 well-formed frames -> 3 o_sof/o_eof pairs, o_frame_cnt=3, o_line_cnt=4, o_pix_cnt=8, o_de high 32 cycles per frame, o_data equals i_data delayed 1 cycle, no errors.
- i_start asserted while i_vsync=1 mid-frame -> that frame produces no o_vsync/o_de; capture begins on the next vs_rise.
- i_skip=2, 7 input frames -> frames 1, 4, 7 captured; o_frame_cnt=3.
- i_stop during the 2nd line of a captured frame -> frame completes with o_eof and o_frame_cnt+1; then IDLE, o_busy=0, the next frame is ignored. i_start+i_stop together in IDLE -> stays IDLE.
- Frame with 7-pixel line 3, then a frame with 5 lines -> o_err_size=1 after the first o_eof; i_clr_err then clears it; the 5-line frame sets it again with o_line_cnt=5.
- TIMEOUT_CYC=256: i_vsync held high 300 cycles during CAP -> o_err_lost=1 at cycle 256, o_vsync=0, no o_eof, state SYNC; the next valid frame is captured normally.
